// File: rtl/udp_tx_pkg.sv
// Shared ethernet framing definitions: framer state encoding and UDP header layout.
// The ARP and ICMP framers import the same package.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_READY    = 3'd2,
    ST_HDR      = 3'd3,
    ST_PAY      = 3'd4,
    ST_WAIT_END = 3'd5
  } frm_state_e;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  localparam logic [2:0] HDR_SRC_HI  = 3'd0;
  localparam logic [2:0] HDR_SRC_LO  = 3'd1;
  localparam logic [2:0] HDR_DST_HI  = 3'd2;
  localparam logic [2:0] HDR_DST_LO  = 3'd3;
  localparam logic [2:0] HDR_LEN_HI  = 3'd4;
  localparam logic [2:0] HDR_LEN_LO  = 3'd5;
  localparam logic [2:0] HDR_CSUM_HI = 3'd6;
  localparam logic [2:0] HDR_CSUM_LO = 3'd7;

  // Checksum bytes stay zero: "not computed" is legal for UDP over IPv4.
  function automatic logic [7:0] udp_hdr_byte(input logic [2:0]  idx,
                                               input logic [15:0] src_port,
                                               input logic [15:0] dst_port,
                                               input logic [15:0] udp_len);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      HDR_SRC_HI:  b = src_port[15:8];
      HDR_SRC_LO:  b = src_port[7:0];
      HDR_DST_HI:  b = dst_port[15:8];
      HDR_DST_LO:  b = dst_port[7:0];
      HDR_LEN_HI:  b = udp_len[15:8];
      HDR_LEN_LO:  b = udp_len[7:0];
      HDR_CSUM_HI: b = 8'h00;
      HDR_CSUM_LO: b = 8'h00;
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_tx.sv
// UDP transmit framer: requests the IP layer, then serves the 8-byte header and
// payload bytes (pulled from the application) one per upper_data_req cycle.
//
// state    | meaning
// IDLE     | waiting for app_tx_start
// REQ      | udp_tx_req high, waiting for ack with timeout
// READY    | granted, waiting for the first pull
// HDR      | serving header bytes 1..7
// PAY      | forwarding payload pulls to the application
// WAIT_END | frame handed off, waiting for mac_send_end
module udp_tx
  import udp_tx_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT  = 16'h1F90,
  parameter logic [15:0] DEST_PORT   = 16'h1F90,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472,
  parameter logic [23:0] ACK_TIMEOUT = 24'd12_500_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        app_tx_start,
  input  logic [15:0] app_tx_length,
  output logic        app_data_req,
  input  logic [7:0]  app_data,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_error,
  output logic        udp_tx_req,
  input  logic        udp_tx_ack,
  output logic        udp_tx_ready,
  output logic [7:0]  udp_tx_data,
  output logic [15:0] udp_send_data_length,
  input  logic        upper_data_req,
  input  logic        mac_send_end
);

  frm_state_e  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] send_len_q, send_len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] tmr_q, tmr_d;
  logic [7:0]  hdr_byte_q, hdr_byte_d;
  logic        sel_pay_q, sel_pay_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_error_q, tx_error_d;

  logic [15:0] pay_last;
  assign pay_last = len_q + UDP_HDR_LEN - 16'd1;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    send_len_d   = send_len_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    hdr_byte_d   = 8'h00;
    sel_pay_d    = 1'b0;
    tx_done_d    = 1'b0;
    tx_error_d   = 1'b0;
    app_data_req = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (app_tx_start) begin
          if (app_tx_length > MAX_PAYLOAD) begin
            tx_error_d = 1'b1;
          end else begin
            len_d      = app_tx_length;
            send_len_d = app_tx_length + UDP_HDR_LEN;
            cnt_d      = 16'd0;
            tmr_d      = ACK_TIMEOUT;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (udp_tx_ack) begin
          state_d = ST_READY;
        end else if (tmr_q <= 24'd1) begin
          tx_error_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 24'd1;
        end
      end
      ST_READY: begin
        if (upper_data_req) begin
          hdr_byte_d = udp_hdr_byte(HDR_SRC_HI, LOCAL_PORT, DEST_PORT, send_len_q);
          cnt_d      = 16'd1;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (upper_data_req) begin
          hdr_byte_d = udp_hdr_byte(cnt_q[2:0], LOCAL_PORT, DEST_PORT, send_len_q);
          cnt_d      = cnt_q + 16'd1;
          if (cnt_q == UDP_HDR_LEN - 16'd1)
            state_d = (len_q == 16'd0) ? ST_WAIT_END : ST_PAY;
        end
      end
      ST_PAY: begin
        // Data arrives from the application next cycle; only the mux select is registered.
        if (upper_data_req) begin
          app_data_req = 1'b1;
          sel_pay_d    = 1'b1;
          cnt_d        = cnt_q + 16'd1;
          if (cnt_q == pay_last)
            state_d = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (mac_send_end) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_q      <= 16'd0;
      send_len_q <= 16'd0;
      cnt_q      <= 16'd0;
      tmr_q      <= 24'd0;
      hdr_byte_q <= 8'h00;
      sel_pay_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      send_len_q <= send_len_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      hdr_byte_q <= hdr_byte_d;
      sel_pay_q  <= sel_pay_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign busy                 = (state_q != ST_IDLE);
  assign udp_tx_req           = (state_q == ST_REQ);
  assign udp_tx_ready         = (state_q == ST_READY) || (state_q == ST_HDR) || (state_q == ST_PAY);
  assign udp_tx_data          = sel_pay_q ? app_data : hdr_byte_q;
  assign udp_send_data_length = send_len_q;
  assign tx_done              = tx_done_q;
  assign tx_error             = tx_error_q;

endmodule

// File: tb/tb_udp_tx.sv
// Self-checking bench for udp_tx: directed scenarios with random payloads, lengths
// and pull gaps, checked against a byte-stream model of the UDP frame.
module tb_udp_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        app_tx_start = 1'b0;
  logic [15:0] app_tx_length = 16'd0;
  logic        app_data_req;
  logic [7:0]  app_data = 8'h00;
  logic        busy;
  logic        tx_done;
  logic        tx_error;
  logic        udp_tx_req;
  logic        udp_tx_ack = 1'b0;
  logic        udp_tx_ready;
  logic [7:0]  udp_tx_data;
  logic [15:0] udp_send_data_length;
  logic        upper_data_req = 1'b0;
  logic        mac_send_end = 1'b0;

  udp_tx #(
    .LOCAL_PORT (16'h1F90),
    .DEST_PORT  (16'h1F90),
    .MAX_PAYLOAD(16'd1472),
    .ACK_TIMEOUT(24'd16)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .app_tx_start        (app_tx_start),
    .app_tx_length       (app_tx_length),
    .app_data_req        (app_data_req),
    .app_data            (app_data),
    .busy                (busy),
    .tx_done             (tx_done),
    .tx_error            (tx_error),
    .udp_tx_req          (udp_tx_req),
    .udp_tx_ack          (udp_tx_ack),
    .udp_tx_ready        (udp_tx_ready),
    .udp_tx_data         (udp_tx_data),
    .udp_send_data_length(udp_send_data_length),
    .upper_data_req      (upper_data_req),
    .mac_send_end        (mac_send_end)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] payload [0:2047];
  logic [7:0] exp_q [$];
  int         pull_k;
  int         app_idx;
  int         app_reqs;
  logic       prev_pull;
  logic       prev_app;
  logic [7:0] prev_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected UDP byte stream: src port, dst port, length (payload + 8), zero checksum, payload.
  task automatic build_expected(input int len);
    logic [15:0] ulen;
    ulen = 16'(len + 8);
    exp_q.delete();
    exp_q.push_back(8'h1F); exp_q.push_back(8'h90);
    exp_q.push_back(8'h1F); exp_q.push_back(8'h90);
    exp_q.push_back(ulen[15:8]); exp_q.push_back(ulen[7:0]);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < len; i++) exp_q.push_back(payload[i]);
    pull_k = 0; app_idx = 0; app_reqs = 0;
    prev_pull = 1'b0; prev_app = 1'b0; prev_exp = 8'h00;
  endtask

  // One clock cycle of the IP-side puller plus the application-side data source.
  task automatic step(input bit pull, input bit start, input logic [15:0] slen, input int frame_len);
    upper_data_req = pull;
    app_tx_start   = start;
    if (start) app_tx_length = slen;
    app_data = prev_app ? payload[app_idx-1] : 8'($urandom);
    #1;
    if (prev_pull) chk("data", {24'd0, udp_tx_data}, {24'd0, prev_exp});
    chk("ready", {31'd0, udp_tx_ready}, (pull_k < exp_q.size()) ? 32'd1 : 32'd0);
    chk("no_done", {31'd0, tx_done}, 32'd0);
    chk("no_err", {31'd0, tx_error}, 32'd0);
    chk("len_stable", {16'd0, udp_send_data_length}, 32'(frame_len + 8));
    if (pull) begin
      chk("app_req", {31'd0, app_data_req},
          (pull_k >= 8 && pull_k < exp_q.size()) ? 32'd1 : 32'd0);
      prev_exp = (pull_k < exp_q.size()) ? exp_q[pull_k] : 8'h00;
      pull_k++;
    end else begin
      chk("app_req_idle", {31'd0, app_data_req}, 32'd0);
    end
    prev_app = app_data_req;
    if (app_data_req) begin
      app_idx++;
      app_reqs++;
    end
    prev_pull = pull;
    tick();
    app_tx_start   = 1'b0;
    upper_data_req = 1'b0;
  endtask

  task automatic start_and_ack(input int len, input int ack_dly);
    app_tx_length = 16'(len);
    app_tx_start  = 1'b1;
    tick();
    app_tx_start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_req", {31'd0, udp_tx_req}, 32'd1);
    chk("start_len", {16'd0, udp_send_data_length}, 32'(len + 8));
    for (int i = 0; i < ack_dly; i++) begin
      mac_send_end = (i == 0);
      tick();
      mac_send_end = 1'b0;
      chk("wait_req", {31'd0, udp_tx_req}, 32'd1);
      chk("wait_no_done", {31'd0, tx_done}, 32'd0);
    end
    udp_tx_ack = 1'b1;
    tick();
    udp_tx_ack = 1'b0;
    chk("ack_req_low", {31'd0, udp_tx_req}, 32'd0);
    chk("ack_ready", {31'd0, udp_tx_ready}, 32'd1);
  endtask

  task automatic run_frame(input int len, input int ack_dly, input bit gaps, input bit mid_start);
    build_expected(len);
    start_and_ack(len, ack_dly);
    for (int p = 0; p < len + 10; p++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) step(1'b0, 1'b0, 16'd0, len);
      end
      step(1'b1, mid_start && (p == 5), 16'd2000, len);
    end
    step(1'b0, 1'b0, 16'd0, len);
    chk("app_req_count", 32'(app_reqs), 32'(len));
    chk("end_busy", {31'd0, busy}, 32'd1);
    mac_send_end = 1'b1;
    tick();
    mac_send_end = 1'b0;
    chk("done_pulse", {31'd0, tx_done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("done_clear", {31'd0, tx_done}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, udp_tx_req}, 32'd0);
    chk({tag, "_ready"}, {31'd0, udp_tx_ready}, 32'd0);
    chk({tag, "_app_req"}, {31'd0, app_data_req}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, tx_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, tx_error}, 32'd0);
    chk({tag, "_data"}, {24'd0, udp_tx_data}, 32'd0);
    chk({tag, "_len"}, {16'd0, udp_send_data_length}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    #12;
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Reference frame: AA BB CC DD, ack after 3 cycles.
    payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC; payload[3] = 8'hDD;
    run_frame(4, 3, 1'b0, 1'b0);

    // Empty payload: header only.
    run_frame(0, 1, 1'b0, 1'b0);

    // Oversize rejected without a request.
    app_tx_length = 16'd1473;
    app_tx_start  = 1'b1;
    tick();
    app_tx_start = 1'b0;
    chk("over_err", {31'd0, tx_error}, 32'd1);
    chk("over_busy", {31'd0, busy}, 32'd0);
    chk("over_req", {31'd0, udp_tx_req}, 32'd0);
    tick();
    chk("over_err_clear", {31'd0, tx_error}, 32'd0);
    chk("over_req2", {31'd0, udp_tx_req}, 32'd0);

    // Largest legal payload.
    for (int i = 0; i < 1472; i++) payload[i] = 8'($urandom);
    run_frame(1472, 0, 1'b0, 1'b0);

    // Ack timeout.
    app_tx_length = 16'd10;
    app_tx_start  = 1'b1;
    tick();
    app_tx_start = 1'b0;
    cnt = 0;
    while (udp_tx_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", 32'(cnt), 32'd16);
    chk("to_err", {31'd0, tx_error}, 32'd1);
    tick();
    chk("to_err_clear", {31'd0, tx_error}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);

    // Random gaps plus an ignored second start.
    begin
      int len;
      len = $urandom_range(6, 40);
      for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
      run_frame(len, $urandom_range(0, 5), 1'b1, 1'b1);
    end

    // Random back-to-back frames.
    for (int f = 0; f < 4; f++) begin
      int len;
      len = $urandom_range(0, 64);
      for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
      run_frame(len, $urandom_range(0, 6), f[0], 1'b0);
    end

    // Reset in the middle of the payload.
    for (int i = 0; i < 6; i++) payload[i] = 8'($urandom);
    build_expected(6);
    start_and_ack(6, 2);
    for (int p = 0; p < 10; p++) step(1'b1, 1'b0, 16'd0, 6);
    upper_data_req = 1'b1;
    rstn = 1'b0;
    #1;
    upper_data_req = 1'b0;
    check_reset_outputs("mid_rst");
    tick();
    tick();
    check_reset_outputs("mid_rst_hold");
    rstn = 1'b1;
    tick();
    chk("post_rst_done", {31'd0, tx_done}, 32'd0);
    chk("post_rst_err", {31'd0, tx_error}, 32'd0);
    for (int i = 0; i < 5; i++) payload[i] = 8'($urandom);
    run_frame(5, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
